// File: rtl/verinject_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// verinject_ctrl_pkg
//   Shared types and helpers for the single-bit fault-injection campaign
//   controller.
//   - state_e   : campaign FSM states, also exported on the debug state port.
//   - NO_INJECT : "inject nothing" code for the injector state bus (all-ones).
//                 Users take the low STATE_W bits.
//   - bit_w     : width of a bit-index field covering 0..max_bit.
//   - lat_w     : width of a latency field covering 0..observe_cycles.
//   - phase_w   : width of a phase counter long enough for the longest
//                 timed phase (reset, settle or observe).
// -----------------------------------------------------------------------------
package verinject_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_SETTLE  = 3'd2,
        S_INJECT  = 3'd3,
        S_OBSERVE = 3'd4,
        S_REPORT  = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    // Injector buses up to 64 bits wide slice their constant from this value.
    localparam logic [63:0] NO_INJECT = '1;

    function automatic int bit_w(input int max_bit);
        return (max_bit < 1) ? 1 : $clog2(max_bit + 1);
    endfunction

    function automatic int lat_w(input int observe_cycles);
        return (observe_cycles < 1) ? 1 : $clog2(observe_cycles + 1);
    endfunction

    function automatic int phase_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/verinject_obs_window.sv
// -----------------------------------------------------------------------------
// verinject_obs_window
//   Compares the golden and injected DUT outputs for one injection run.
//   - During settle it raises a sticky prefault flag on any mismatch.
//   - During observe it counts window cycles (1 on the first cycle) and
//     captures the cycle number of the first mismatch as the latency.
//   Outputs are the next-state view of the flags: they already include the
//   mismatch seen in the current cycle, so the controller can load its result
//   registers on the same edge that closes the window.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clear_i             clear all per-run state (entry to a new run)
//   settle_en_i         current cycle belongs to the settle phase
//   observe_en_i        current cycle belongs to the observation window
//   golden_i            output of the uninjected DUT
//   injected_i          output of the injected DUT
//   detected_o          a mismatch has been seen inside the window
//   latency_o           window cycle of the first mismatch, 0 if none
//   prefault_o          a mismatch has been seen during settle
// -----------------------------------------------------------------------------
module verinject_obs_window
    import verinject_ctrl_pkg::*;
#(
    parameter int CMP_W          = 32,
    parameter int OBSERVE_CYCLES = 16,
    localparam int LW            = lat_w(OBSERVE_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             settle_en_i,
    input  logic             observe_en_i,
    input  logic [CMP_W-1:0] golden_i,
    input  logic [CMP_W-1:0] injected_i,
    output logic             detected_o,
    output logic [LW-1:0]    latency_o,
    output logic             prefault_o
);

    logic          mismatch;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          det_q, det_d;
    logic          pre_q, pre_d;

    assign mismatch = (golden_i != injected_i);

    always_comb begin
        cnt_d = cnt_q;
        lat_d = lat_q;
        det_d = det_q;
        pre_d = pre_q;
        if (clear_i) begin
            cnt_d = '0;
            lat_d = '0;
            det_d = 1'b0;
            pre_d = 1'b0;
        end else begin
            if (settle_en_i && mismatch) begin
                pre_d = 1'b1;
            end
            if (observe_en_i) begin
                // cnt_q + 1 is the number of the current window cycle.
                cnt_d = cnt_q + LW'(1);
                if (mismatch && !det_q) begin
                    det_d = 1'b1;
                    lat_d = cnt_q + LW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            lat_q <= '0;
            det_q <= 1'b0;
            pre_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lat_q <= lat_d;
            det_q <= det_d;
            pre_q <= pre_d;
        end
    end

    assign detected_o = det_d;
    assign latency_o  = lat_d;
    assign prefault_o = pre_d;

endmodule

// File: rtl/verinject_campaign_ctrl.sv
// -----------------------------------------------------------------------------
// verinject_campaign_ctrl
//   Runs an exhaustive single-bit fault-injection campaign over a golden /
//   injected DUT pair. For each bit index 0..MAX_BIT: hold the DUT pair in
//   reset, let it settle, inject one fault for one cycle, watch the outputs
//   for OBSERVE_CYCLES cycles, then report one result record.
//
//   The result record is a strobe: result_valid_o is high for exactly one
//   cycle per index with no back-pressure; the result_* fields stay stable
//   until the next strobe.
//
// Ports
//   clk_i               clock, rising edge
//   rst_i               asynchronous active-high reset
//   start_i             begin campaign (sampled only in IDLE or DONE)
//   abort_i             abandon campaign, back to IDLE (highest priority)
//   golden_out_i        output of the uninjected DUT
//   injected_out_i      output of the injected DUT
//   injector_state_o    injection target, NO_INJECT except in INJECT
//   dut_rst_o           reset to both DUT copies
//   busy_o              campaign in progress
//   done_o              campaign complete
//   result_valid_o      one-cycle strobe per bit index
//   result_bit_o        bit index just tested
//   result_detected_o   mismatch seen in the observation window
//   result_latency_o    window cycle of the first mismatch (0 if none)
//   result_prefault_o   mismatch seen while settling (contaminated run)
//   detected_count_o    number of indices reported as detected
//   state_o             current FSM state (debug)
// -----------------------------------------------------------------------------
module verinject_campaign_ctrl
    import verinject_ctrl_pkg::*;
#(
    parameter int STATE_W        = 32,
    parameter int MAX_BIT        = 96,
    parameter int RESET_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int OBSERVE_CYCLES = 16,
    parameter int CMP_W          = 32,
    localparam int BW            = bit_w(MAX_BIT),
    localparam int LW            = lat_w(OBSERVE_CYCLES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [CMP_W-1:0]   golden_out_i,
    input  logic [CMP_W-1:0]   injected_out_i,
    output logic [STATE_W-1:0] injector_state_o,
    output logic               dut_rst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               result_valid_o,
    output logic [BW-1:0]      result_bit_o,
    output logic               result_detected_o,
    output logic [LW-1:0]      result_latency_o,
    output logic               result_prefault_o,
    output logic [BW:0]        detected_count_o,
    output state_e             state_o
);

    localparam int CW   = phase_w(RESET_CYCLES, SETTLE_CYCLES, OBSERVE_CYCLES);
    localparam int CNTW = BW + 1;
    localparam logic [STATE_W-1:0] NO_INJ = NO_INJECT[STATE_W-1:0];

    // A bit index equal to NO_INJECT would be indistinguishable from "no
    // fault", and every timed phase needs at least one cycle.
    if (STATE_W > 64 ||
        (STATE_W < 32 && MAX_BIT >= (1 << STATE_W) - 1) ||
        RESET_CYCLES < 1 || SETTLE_CYCLES < 1 || OBSERVE_CYCLES < 1 ||
        MAX_BIT < 0) begin : g_bad_params
        $error("verinject_campaign_ctrl: illegal parameter combination");
    end

    state_e               state_q, state_d;
    logic [CW-1:0]        phase_q, phase_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [STATE_W-1:0]   inj_q, inj_d;
    logic                 dut_rst_q, dut_rst_d;
    logic                 rv_q, rv_d;
    logic [BW-1:0]        rbit_q, rbit_d;
    logic                 rdet_q, rdet_d;
    logic [LW-1:0]        rlat_q, rlat_d;
    logic                 rpre_q, rpre_d;
    logic [CNTW-1:0]      count_q, count_d;
    logic                 campaign_clear;
    logic                 win_clear;
    logic                 win_det;
    logic [LW-1:0]        win_lat;
    logic                 win_pre;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        bit_d          = bit_q;
        campaign_clear = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d        = S_RESET;
                    campaign_clear = 1'b1;
                end
            end
            S_RESET: begin
                if (phase_q == CW'(RESET_CYCLES - 1)) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (phase_q == CW'(SETTLE_CYCLES - 1)) state_d = S_INJECT;
            end
            S_INJECT: begin
                state_d = S_OBSERVE;
            end
            S_OBSERVE: begin
                if (phase_q == CW'(OBSERVE_CYCLES - 1)) state_d = S_REPORT;
            end
            S_REPORT: begin
                if (bit_q == BW'(MAX_BIT)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RESET;
                    bit_d   = bit_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides start and the REPORT hand-off alike.
        if (abort_i) begin
            state_d        = S_IDLE;
            bit_d          = bit_q;
            campaign_clear = 1'b0;
        end
        if (campaign_clear) begin
            bit_d = '0;
        end
    end

    // Phase counter restarts on every state change and only runs in the
    // timed phases.
    always_comb begin
        phase_d = '0;
        if (state_d == state_q &&
            (state_q == S_RESET || state_q == S_SETTLE || state_q == S_OBSERVE)) begin
            phase_d = phase_q + CW'(1);
        end
    end

    assign win_clear = (state_d == S_RESET) && (state_q != S_RESET);

    verinject_obs_window #(
        .CMP_W          (CMP_W),
        .OBSERVE_CYCLES (OBSERVE_CYCLES)
    ) u_obs_window (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (win_clear),
        .settle_en_i  (state_q == S_SETTLE),
        .observe_en_i (state_q == S_OBSERVE),
        .golden_i     (golden_out_i),
        .injected_i   (injected_out_i),
        .detected_o   (win_det),
        .latency_o    (win_lat),
        .prefault_o   (win_pre)
    );

    // ------------------------------------------------------------------
    // Registered outputs, computed from the next state so that each output
    // lines up with the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        inj_d     = (state_d == S_INJECT) ? STATE_W'(bit_d) : NO_INJ;
        dut_rst_d = (state_d == S_RESET);
        rv_d      = (state_d == S_REPORT);
        rbit_d    = rbit_q;
        rdet_d    = rdet_q;
        rlat_d    = rlat_q;
        rpre_d    = rpre_q;
        count_d   = count_q;
        if (campaign_clear) begin
            count_d = '0;
        end
        if (state_d == S_REPORT) begin
            rbit_d = bit_q;
            rdet_d = win_det;
            rlat_d = win_lat;
            rpre_d = win_pre;
            if (win_det) begin
                count_d = count_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            inj_q     <= NO_INJ;
            dut_rst_q <= 1'b1;
            rv_q      <= 1'b0;
            rbit_q    <= '0;
            rdet_q    <= 1'b0;
            rlat_q    <= '0;
            rpre_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            inj_q     <= inj_d;
            dut_rst_q <= dut_rst_d;
            rv_q      <= rv_d;
            rbit_q    <= rbit_d;
            rdet_q    <= rdet_d;
            rlat_q    <= rlat_d;
            rpre_q    <= rpre_d;
            count_q   <= count_d;
        end
    end

    assign injector_state_o  = inj_q;
    assign dut_rst_o         = dut_rst_q;
    assign busy_o            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o            = (state_q == S_DONE);
    assign result_valid_o    = rv_q;
    assign result_bit_o      = rbit_q;
    assign result_detected_o = rdet_q;
    assign result_latency_o  = rlat_q;
    assign result_prefault_o = rpre_q;
    assign detected_count_o  = count_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_verinject_campaign_ctrl.sv
// -----------------------------------------------------------------------------
// tb_verinject_campaign_ctrl
//   Drives whole campaigns with a per-run mismatch plan and predicts every
//   cycle from the campaign timing: run k starts RUN*k cycles after the start
//   edge; offsets 0..RC-1 are reset, RC..RC+SC-1 settle, INJ_OFF inject,
//   INJ_OFF+1..INJ_OFF+OC observe, REP_OFF report.
// -----------------------------------------------------------------------------
module tb_verinject_campaign_ctrl;
    import verinject_ctrl_pkg::*;

    localparam int STATE_W = 32;
    localparam int MAX_BIT = 96;
    localparam int RC      = 2;
    localparam int SC      = 8;
    localparam int OC      = 16;
    localparam int CMP_W   = 32;
    localparam int BW      = 7;
    localparam int LW      = 5;
    localparam int NRUN    = MAX_BIT + 1;
    localparam int RUN     = RC + SC + 1 + OC + 1;
    localparam int INJ_OFF = RC + SC;
    localparam int REP_OFF = RUN - 1;
    localparam int REC_W   = BW + 1 + LW + 1;
    localparam int STOP_NONE  = 0;
    localparam int STOP_ABORT = 1;
    localparam int STOP_RST   = 2;
    localparam logic [63:0] ALL_ONES = 64'h0000_0000_FFFF_FFFF;

    logic               clk_i;
    logic               rst_i;
    logic               start_i;
    logic               abort_i;
    logic [CMP_W-1:0]   golden_out_i;
    logic [CMP_W-1:0]   injected_out_i;
    logic [STATE_W-1:0] injector_state_o;
    logic               dut_rst_o;
    logic               busy_o;
    logic               done_o;
    logic               result_valid_o;
    logic [BW-1:0]      result_bit_o;
    logic               result_detected_o;
    logic [LW-1:0]      result_latency_o;
    logic               result_prefault_o;
    logic [BW:0]        detected_count_o;
    state_e             state_o;

    verinject_campaign_ctrl #(
        .STATE_W        (STATE_W),
        .MAX_BIT        (MAX_BIT),
        .RESET_CYCLES   (RC),
        .SETTLE_CYCLES  (SC),
        .OBSERVE_CYCLES (OC),
        .CMP_W          (CMP_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .golden_out_i      (golden_out_i),
        .injected_out_i    (injected_out_i),
        .injector_state_o  (injector_state_o),
        .dut_rst_o         (dut_rst_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .result_valid_o    (result_valid_o),
        .result_bit_o      (result_bit_o),
        .result_detected_o (result_detected_o),
        .result_latency_o  (result_latency_o),
        .result_prefault_o (result_prefault_o),
        .detected_count_o  (detected_count_o),
        .state_o           (state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int               n_tests = 0;
    int               n_fail  = 0;
    bit               plan [NRUN][RUN];
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] last_rec;
    int               exp_count;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference: what one run should report, straight from the plan.
    function automatic logic [REC_W-1:0] model_rec(input int k);
        logic pre;
        logic det;
        int   lat;
        pre = 1'b0;
        det = 1'b0;
        lat = 0;
        for (int off = RC; off < RC + SC; off++) begin
            if (plan[k][off]) pre = 1'b1;
        end
        for (int c = 1; c <= OC; c++) begin
            if (plan[k][INJ_OFF + c] && !det) begin
                det = 1'b1;
                lat = c;
            end
        end
        return {BW'(k), det, LW'(lat), pre};
    endfunction

    task automatic clear_plan();
        for (int k = 0; k < NRUN; k++)
            for (int off = 0; off < RUN; off++)
                plan[k][off] = 1'b0;
    endtask

    task automatic make_random_plan();
        clear_plan();
        for (int k = 0; k < NRUN; k++) begin
            case ($urandom_range(0, 5))
                0: ;
                1: plan[k][RC + $urandom_range(0, SC - 1)] = 1'b1;
                2: plan[k][INJ_OFF + $urandom_range(1, OC)] = 1'b1;
                3: for (int c = 1; c <= OC; c++) plan[k][INJ_OFF + c] = ($urandom_range(0, 2) == 0);
                4: begin
                    // Mismatches outside settle/observe must be ignored.
                    plan[k][$urandom_range(0, RC - 1)] = 1'b1;
                    plan[k][INJ_OFF] = 1'b1;
                    plan[k][REP_OFF] = 1'b1;
                end
                default: begin
                    plan[k][RC + $urandom_range(0, SC - 1)] = 1'b1;
                    plan[k][INJ_OFF + $urandom_range(1, OC)] = 1'b1;
                end
            endcase
        end
    endtask

    task automatic make_directed_plan();
        clear_plan();
        plan[1][RC + 3]      = 1'b1;  // settle mismatch on bit 1
        plan[2][INJ_OFF + 3] = 1'b1;  // third observe cycle of bit 2
        plan[3][INJ_OFF]     = 1'b1;  // inject cycle only
        plan[3][REP_OFF]     = 1'b1;  // report cycle only
        plan[4][INJ_OFF + OC] = 1'b1; // last observe cycle of bit 4
    endtask

    task automatic drive_cycle(input bit mis);
        golden_out_i   = $urandom;
        injected_out_i = mis ? (golden_out_i ^ ($urandom | 32'd1)) : golden_out_i;
    endtask

    task automatic check_fields();
        check_eq("result_bit",      64'(result_bit_o),      64'(last_rec[REC_W-1 -: BW]));
        check_eq("result_detected", 64'(result_detected_o), 64'(last_rec[LW+1]));
        check_eq("result_latency",  64'(result_latency_o),  64'(last_rec[LW:1]));
        check_eq("result_prefault", 64'(result_prefault_o), 64'(last_rec[0]));
    endtask

    // Called at a negedge with the DUT in IDLE or DONE.
    task automatic run_campaign(input int stop_kind, input int stop_run, input int stop_off);
        exp_q.delete();
        for (int k = 0; k < NRUN; k++) exp_q.push_back(model_rec(k));
        exp_count = 0;
        start_i = 1'b1;
        drive_cycle(1'b0);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int j = 0; j < NRUN * RUN; j++) begin
            int k;
            int off;
            k   = j / RUN;
            off = j % RUN;
            check_eq("injector_state", 64'(injector_state_o), (off == INJ_OFF) ? 64'(k) : ALL_ONES);
            check_eq("dut_rst", 64'(dut_rst_o), 64'(off < RC));
            check_eq("busy", 64'(busy_o), 64'd1);
            check_eq("done", 64'(done_o), 64'd0);
            check_eq("result_valid", 64'(result_valid_o), 64'(off == REP_OFF));
            if (off == REP_OFF) begin
                check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    last_rec = exp_q.pop_front();
                    if (last_rec[LW+1]) exp_count++;
                end
            end
            check_fields();
            check_eq("detected_count", 64'(detected_count_o), 64'(exp_count));
            if (stop_kind == STOP_ABORT && k == stop_run && off == stop_off) begin
                abort_i = 1'b1;
                start_i = 1'($urandom_range(0, 1));
                drive_cycle(plan[k][off]);
                @(negedge clk_i);
                abort_i = 1'b0;
                start_i = 1'b0;
                check_eq("abort_state", 64'(state_o), 64'(S_IDLE));
                check_eq("abort_injector", 64'(injector_state_o), ALL_ONES);
                check_eq("abort_busy", 64'(busy_o), 64'd0);
                check_eq("abort_result_valid", 64'(result_valid_o), 64'd0);
                check_eq("abort_dut_rst", 64'(dut_rst_o), 64'd0);
                check_eq("abort_count_hold", 64'(detected_count_o), 64'(exp_count));
                check_fields();
                exp_q.delete();
                return;
            end
            if (stop_kind == STOP_RST && k == stop_run && off == INJ_OFF) begin
                #2 rst_i = 1'b1;
                #1;
                last_rec = '0;
                check_eq("arst_injector", 64'(injector_state_o), ALL_ONES);
                check_eq("arst_dut_rst", 64'(dut_rst_o), 64'd1);
                check_eq("arst_busy", 64'(busy_o), 64'd0);
                check_eq("arst_state", 64'(state_o), 64'(S_IDLE));
                check_eq("arst_count", 64'(detected_count_o), 64'd0);
                check_eq("arst_result_valid", 64'(result_valid_o), 64'd0);
                check_fields();
                @(negedge clk_i);
                rst_i = 1'b0;
                exp_q.delete();
                return;
            end
            // Stray start pulses while busy must be ignored.
            start_i = ($urandom_range(0, 15) == 0);
            drive_cycle(plan[k][off]);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        check_eq("final_done", 64'(done_o), 64'd1);
        check_eq("final_busy", 64'(busy_o), 64'd0);
        check_eq("final_state", 64'(state_o), 64'(S_DONE));
        check_eq("final_injector", 64'(injector_state_o), ALL_ONES);
        check_eq("final_dut_rst", 64'(dut_rst_o), 64'd0);
        check_eq("final_result_valid", 64'(result_valid_o), 64'd0);
        check_eq("final_count", 64'(detected_count_o), 64'(exp_count));
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        check_fields();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_i          = 1'b1;
        start_i        = 1'b0;
        abort_i        = 1'b0;
        golden_out_i   = '0;
        injected_out_i = '0;
        last_rec       = '0;
        exp_count      = 0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_injector", 64'(injector_state_o), ALL_ONES);
        check_eq("rst_dut_rst", 64'(dut_rst_o), 64'd1);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_result_valid", 64'(result_valid_o), 64'd0);
        check_eq("rst_count", 64'(detected_count_o), 64'd0);
        check_eq("rst_state", 64'(state_o), 64'(S_IDLE));
        check_fields();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("idle_dut_rst", 64'(dut_rst_o), 64'd0);
        check_eq("idle_state", 64'(state_o), 64'(S_IDLE));

        // Full random campaign from IDLE.
        make_random_plan();
        run_campaign(STOP_NONE, 0, 0);

        // Directed campaign restarted from DONE.
        make_directed_plan();
        run_campaign(STOP_NONE, 0, 0);

        // Abort on the last OBSERVE cycle of bit 5, with a detection banked.
        make_random_plan();
        plan[0][INJ_OFF + 1] = 1'b1;
        run_campaign(STOP_ABORT, 5, INJ_OFF + OC);

        // Restart from IDLE after the abort: bits from 0, count from 0.
        make_random_plan();
        run_campaign(STOP_NONE, 0, 0);

        // Abort at a random point of an early run.
        make_random_plan();
        run_campaign(STOP_ABORT, $urandom_range(0, 6), $urandom_range(0, RUN - 1));

        // Asynchronous reset between edges during INJECT.
        make_random_plan();
        run_campaign(STOP_RST, $urandom_range(0, 40), INJ_OFF);

        // Full campaign after the reset.
        make_random_plan();
        run_campaign(STOP_NONE, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/verinject_campaign_ctrl.md
Name: verinject_campaign_ctrl

Overview:
- Sequences an exhaustive single-bit fault-injection campaign over a golden/injected DUT pair.
- Per target bit index: reset both DUT copies, let them settle, inject one fault for one cycle, then compare outputs over an observation window.
- Emits one result record per index and a running detection count.
- Replaces free-running injector counters in benches; also usable as an on-chip campaign engine.

Parameters:
- STATE_W, 32: width of injector state bus.
- MAX_BIT, 96: last bit index injected; the campaign covers 0..MAX_BIT inclusive.
- RESET_CYCLES, 2: cycles dut_rst is held per run.
- SETTLE_CYCLES, 8: fault-free cycles after DUT reset, before injection.
- OBSERVE_CYCLES, 16: comparison window after injection.
- CMP_W, 32: width of compared DUT outputs.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin campaign; sampled only in IDLE or DONE.
- abort  in  1  abandon campaign; return to IDLE.
- golden_out  in  CMP_W  output of the uninjected DUT.
- injected_out  in  CMP_W  output of the injected DUT.
- injector_state  out  STATE_W  drives verinject__injector_state.
- dut_rst  out  1  reset to both DUT copies.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high while in DONE.
- result_valid  out  1  one-cycle strobe per bit index.
- result_bit  out  BW  index just tested; BW = $clog2(MAX_BIT+1).
- result_detected  out  1  a mismatch occurred in the observation window.
- result_latency  out  LW  cycles from injection to first mismatch; LW = $clog2(OBSERVE_CYCLES+1).
- result_prefault  out  1  a mismatch occurred during SETTLE (contaminated run).
- detected_count  out  BW+1  running count of indices with result_detected=1.

Behaviour:
- Reset (async, rst=1) values:
  - injector_state = all-ones (NO_INJECT).
  - dut_rst = 1.
  - All other outputs 0.
  - State IDLE; bit counter 0.
- Registered outputs: injector_state, dut_rst and all result_* are registered, with no combinational path from inputs.
- Only one injection per run: injector_state holds NO_INJECT in every state except INJECT.
- IDLE:
  - dut_rst=0.
  - On start: clear detected_count and bit counter, then go to RESET.
- RESET:
  - dut_rst=1 for exactly RESET_CYCLES cycles, then SETTLE.
- SETTLE:
  - dut_rst=0 for SETTLE_CYCLES cycles.
  - Any golden_out!=injected_out sets a prefault flag.
  - Then go to INJECT.
- INJECT:
  - Exactly 1 cycle; injector_state = zero-extended bit counter.
  - Then go to OBSERVE.
- OBSERVE:
  - Lasts OBSERVE_CYCLES cycles; the cycle count is 1 on the first OBSERVE cycle.
  - On the first mismatch, record latency = cycle count and set detected.
  - Later mismatches do not change the recorded latency.
  - The window always runs to full length.
  - Then go to REPORT.
- REPORT:
  - result_valid=1 for 1 cycle with the bit, detected, latency (0 if not detected) and prefault values.
  - detected_count increments in the same cycle if detected.
  - If bit counter==MAX_BIT: go to DONE. Otherwise increment the bit counter and go to RESET.
- Per-index latency: RESET_CYCLES + SETTLE_CYCLES + 1 + OBSERVE_CYCLES + 1 cycles (28 with defaults).
- DONE:
  - done=1, dut_rst=0.
  - detected_count holds its value.
  - start restarts the campaign (counter cleared).
- abort:
  - Takes effect from any state; next state is IDLE.
  - injector_state=NO_INJECT next cycle; no result_valid is emitted.
  - abort has priority over start and over the REPORT transition.
- start while busy: ignored.
- rst asserted mid-campaign: immediate reset values; the campaign is lost.
- MAX_BIT must satisfy MAX_BIT < 2^STATE_W - 1, so no index aliases NO_INJECT. Enforce with an elaboration-time check.
- Flag clearing:
  - Per-run prefault, detected and latency are cleared on entry to RESET.
  - result_* values hold after REPORT until the next REPORT.

Decomposition:
- Package verinject_ctrl_pkg:
  - State enum {IDLE, RESET, SETTLE, INJECT, OBSERVE, REPORT, DONE}.
  - NO_INJECT constant (all-ones).
  - Width helper functions for BW and LW.
- Sub-module verinject_obs_window:
  - Contains the mismatch comparator, first-mismatch latency capture and prefault flag.
  - Controls: clear/settle/observe enables.
  - The top block holds the FSM, counters and result registers.

Test Plan:
- Identical outputs (injected_out tied to golden_out), MAX_BIT=3, start pulse:
  - 4 result_valid strobes with bits 0,1,2,3, all detected=0.
  - done after 4×28=112 cycles; detected_count=0.
- injected_out differs from golden_out only on the 3rd OBSERVE cycle when bit==2:
  - Bit 2 reports detected=1, latency=3; other bits report detected=0.
  - Final detected_count=1.
- Mismatch forced during SETTLE of bit 1:
  - Bit 1 reports prefault=1; other bits report prefault=0.
- abort asserted during OBSERVE of bit 5 (MAX_BIT=96):
  - Next cycle: IDLE, injector_state=32'hFFFFFFFF, busy=0, no result_valid.
  - A subsequent start restarts from bit 0 with detected_count=0.
- Injector trace check over a full default campaign:
  - injector_state != all-ones on exactly 97 cycles, each value = 0..96 in order.
  - dut_rst high exactly 2 cycles before each injection run.
- Async rst pulsed between clock edges during INJECT:
  - Outputs take reset values immediately; injector_state=all-ones; dut_rst=1.
